// File: rtl/dtcm_ctrl_pkg.sv
// Shared constants for the DTCM controller slice: RAM geometry and response
// queue depth, plus a width helper used by the controller and its FIFO.
package dtcm_ctrl_pkg;

  localparam int DTCM_XLEN      = 32;
  localparam int DTCM_RAM_AW    = 10;
  localparam int DTCM_RAM_DW    = DTCM_XLEN;
  localparam int DTCM_RSP_DEPTH = 2;

  // Occupancy counter width: must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int rsp_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dtcm_ctrl_if.sv
// LSU <-> DTCM command/response handshake. The LSU is the master (drives
// commands, accepts responses); the controller is the slave.
interface dtcm_ctrl_if
  import dtcm_ctrl_pkg::*;
#(
  parameter int AW = DTCM_RAM_AW,
  parameter int DW = DTCM_RAM_DW
);

  logic              dtcm_cmd_valid;
  logic              dtcm_cmd_ready;
  logic              dtcm_cmd_read;
  logic [AW-1:0]     dtcm_cmd_addr;
  logic [DW-1:0]     dtcm_cmd_wdata;
  logic [DW/8-1:0]   dtcm_cmd_wmask;

  logic              dtcm_rsp_valid;
  logic              dtcm_rsp_ready;
  logic [DW-1:0]     dtcm_rsp_rdata;

  modport master (
    output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr,
           dtcm_cmd_wdata, dtcm_cmd_wmask, dtcm_rsp_ready,
    input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata
  );

  modport slave (
    input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr,
           dtcm_cmd_wdata, dtcm_cmd_wmask, dtcm_rsp_ready,
    output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata
  );

endinterface

// File: rtl/dtcm_rsp_fifo.sv
// Response queue for the DTCM controller: plain synchronous FIFO with
// registered storage and no push-to-head bypass, so the head only changes
// on the clock edge after a pop or after the first push into an empty queue.
module dtcm_rsp_fifo
  import dtcm_ctrl_pkg::*;
#(
  parameter int DW    = DTCM_RAM_DW,
  parameter int DEPTH = DTCM_RSP_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = rsp_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pointer wrap relies on natural binary rollover.
  if (DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_depth
    $error("dtcm_rsp_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count alone while both pointers advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  // The controller's credit scheme reserves a slot for every in-flight
  // access, so a push can never land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (count < DEPTH_C));

  // The response valid is derived from a non-zero count, so pop implies data.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    pop |-> (count != '0));

endmodule

// File: rtl/dtcm_ctrl.sv
// DTCM controller: responder for the LSU cmd/rsp handshake. Accepted
// commands drive the single-port SRAM in the same cycle; the SRAM result
// returns one cycle later and is queued so the LSU can stall responses
// without losing read data. One response per command, strictly in order.
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int AW        = DTCM_RAM_AW,
  parameter int DW        = DTCM_RAM_DW,
  parameter int RSP_DEPTH = DTCM_RSP_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  dtcm_ctrl_if.slave      bus,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW/8-1:0] ram_wem,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  localparam int CW = rsp_cnt_w(RSP_DEPTH);
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(RSP_DEPTH);

  logic          accept_p0;
  logic          vld_p1;
  logic          is_read_p1;
  logic [DW-1:0] push_data_p1;
  logic          pop;
  logic [CW-1:0] count;
  logic [DW-1:0] head;
  logic [CW:0]   credit_used;

  // ---- p0: credit check, accept, SRAM drive ----

  // A slot is free when queued plus in-flight responses, less the one
  // leaving this cycle, is below the queue depth. Counting the pop lets a
  // full queue keep accepting at one command per cycle while rsp_ready=1.
  always_comb begin
    bus.dtcm_rsp_valid = !rst && (count != '0);
    bus.dtcm_rsp_rdata = head;
    pop                = bus.dtcm_rsp_valid && bus.dtcm_rsp_ready;
    credit_used        = {1'b0, count}
                       + {{CW{1'b0}}, vld_p1}
                       - {{CW{1'b0}}, pop};
    bus.dtcm_cmd_ready = !rst && (credit_used < DEPTH_LIM);
    accept_p0          = bus.dtcm_cmd_valid && bus.dtcm_cmd_ready;
  end

  // SRAM is driven directly from the accepted command; reads never write
  // any byte, and a write with an all-zero mask still issues a cycle.
  always_comb begin
    ram_cs   = accept_p0;
    ram_we   = accept_p0 && !bus.dtcm_cmd_read;
    ram_addr = bus.dtcm_cmd_addr;
    ram_wem  = bus.dtcm_cmd_read ? '0 : bus.dtcm_cmd_wmask;
    ram_din  = bus.dtcm_cmd_wdata;
  end

  // ---- p1: SRAM data returns, response enters the queue ----

  // In-flight marker; clearing it on reset discards the SRAM result that
  // is still on its way back.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept_p0;
  end

  // Command kind travels with the in-flight marker to pick the payload.
  always_ff @(posedge clk) begin
    if (accept_p0) is_read_p1 <= bus.dtcm_cmd_read;
  end

  // Write responses carry zero so the LSU never sees stale SRAM output.
  always_comb begin
    push_data_p1 = is_read_p1 ? ram_dout : '0;
  end

  // ---- response: queue head presented to the LSU ----

  dtcm_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (push_data_p1),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // A stalled response must hold its data until the LSU takes it.
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.dtcm_rsp_valid && !bus.dtcm_rsp_ready)
      |=> (bus.dtcm_rsp_valid && $stable(bus.dtcm_rsp_rdata)));

  // Outstanding work never exceeds the reserved queue space.
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count} + {{CW{1'b0}}, vld_p1}) <= DEPTH_LIM);

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed bench for dtcm_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_dtcm_ctrl;
  import dtcm_ctrl_pkg::*;

  localparam int AW    = DTCM_RAM_AW;
  localparam int DW    = DTCM_RAM_DW;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ram_cs;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [MW-1:0]   ram_wem;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;

  dtcm_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  dtcm_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wem  (ram_wem),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // SRAM model; words 0..15 hold addr*3 whenever reset is asserted.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end else if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(i * 3);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] rsp_q[$];
  int            rsp_cyc_q[$];
  int            acc_cyc_q[$];

  // Record handshakes mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst && bus.dtcm_rsp_valid && bus.dtcm_rsp_ready) begin
      rsp_q.push_back(bus.dtcm_rsp_rdata);
      rsp_cyc_q.push_back(cyc);
    end
    if (!rst && bus.dtcm_cmd_valid && bus.dtcm_cmd_ready)
      acc_cyc_q.push_back(cyc);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rsp_at(input int i);
    return (i < rsp_q.size()) ? rsp_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int rcyc_at(input int i);
    return (i < rsp_cyc_q.size()) ? rsp_cyc_q[i] : -1000;
  endfunction
  function automatic int acyc_at(input int i);
    return (i < acc_cyc_q.size()) ? acc_cyc_q[i] : -1000;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    rsp_q.delete(); rsp_cyc_q.delete(); acc_cyc_q.delete();
  endtask

  // Present one command (called just after a rising edge) and hold it until taken.
  task automatic send(input logic rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    int n;
    n = 0;
    bus.dtcm_cmd_valid = 1'b1;
    bus.dtcm_cmd_read  = rd;
    bus.dtcm_cmd_addr  = a;
    bus.dtcm_cmd_wdata = wd;
    bus.dtcm_cmd_wmask = wm;
    @(negedge clk);
    while (!bus.dtcm_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_accept_budget", 32'(n), 32'd0);
    sync();
    bus.dtcm_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int c = 0; c < 100 && rsp_q.size() < n; c++) begin
      @(negedge clk); #1;
    end
    chk(tag, 32'(rsp_q.size()), 32'(n));
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;
    int   k;
    int   n_acc;
    bus.dtcm_cmd_valid = 1'b0;
    bus.dtcm_cmd_read  = 1'b0;
    bus.dtcm_cmd_addr  = '0;
    bus.dtcm_cmd_wdata = '0;
    bus.dtcm_cmd_wmask = '0;
    bus.dtcm_rsp_ready = 1'b0;

    // 1: reset held 3 cycles, then released
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cmd_ready", 32'(bus.dtcm_cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.dtcm_rsp_valid), 32'd0);
    end
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.dtcm_cmd_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(bus.dtcm_rsp_valid), 32'd0);
    sync();

    // 2: write then read back the same word
    clear_q();
    bus.dtcm_rsp_ready = 1'b1;
    send(1'b0, AW'('h10), 32'hDEADBEEF, 4'hF);
    send(1'b1, AW'('h10), 32'h0, 4'h0);
    wait_rsp(2, "t2_rsp_count");
    chk("t2_wr_rdata", rsp_at(0), 32'h0);
    chk("t2_rd_rdata", rsp_at(1), 32'hDEADBEEF);
    chk("t2_rd_latency", 32'(rcyc_at(1) - acyc_at(1)), 32'd2);

    // 3: byte-masked write merges into existing word
    clear_q();
    send(1'b0, AW'('h20), 32'h11223344, 4'hF);
    send(1'b0, AW'('h20), 32'hAABBCCDD, 4'h5);
    send(1'b1, AW'('h20), 32'h0, 4'h0);
    wait_rsp(3, "t3_rsp_count");
    chk("t3_wr0_rdata", rsp_at(0), 32'h0);
    chk("t3_wr1_rdata", rsp_at(1), 32'h0);
    chk("t3_rd_merged", rsp_at(2), 32'h11BB33DD);

    // 4: back-to-back reads of preloaded words
    clear_q();
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i), 32'h0, 4'h0);
    wait_rsp(8, "t4_rsp_count");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_rdata_%0d", i), rsp_at(i), 32'(3 * i));
      chk($sformatf("t4_acc_cyc_%0d", i), 32'(acyc_at(i) - acyc_at(0)), 32'(i));
      chk($sformatf("t4_rsp_cyc_%0d", i), 32'(rcyc_at(i) - rcyc_at(0)), 32'(i));
    end

    // 5: backpressure on rsp, then drain with continuous commands
    clear_q();
    bus.dtcm_rsp_ready = 1'b0;
    k = 4;
    n_acc = 0;
    bus.dtcm_cmd_valid = 1'b1;
    bus.dtcm_cmd_read  = 1'b1;
    bus.dtcm_cmd_addr  = AW'(k);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); got = bus.dtcm_cmd_ready;
      sync();
      if (got) begin k++; n_acc++; bus.dtcm_cmd_addr = AW'(k); end
    end
    @(negedge clk); #1;
    chk("t5_bp_accepts", 32'(acc_cyc_q.size()), 32'(DEPTH));
    chk("t5_bp_ready_low", 32'(bus.dtcm_cmd_ready), 32'd0);
    chk("t5_bp_no_rsp", 32'(rsp_q.size()), 32'd0);
    sync();
    bus.dtcm_rsp_ready = 1'b1;
    for (int c = 0; c < 100 && n_acc < 8; c++) begin
      @(negedge clk); got = bus.dtcm_cmd_ready;
      sync();
      if (got) begin k++; n_acc++; bus.dtcm_cmd_addr = AW'(k); end
    end
    bus.dtcm_cmd_valid = 1'b0;
    wait_rsp(8, "t5_rsp_count");
    chk("t5_acc_count", 32'(acc_cyc_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t5_rdata_%0d", i), rsp_at(i), 32'(3 * (4 + i)));

    // 6: reset with two queued responses and one read in flight
    clear_q();
    bus.dtcm_rsp_ready = 1'b0;
    send(1'b1, AW'(1), 32'h0, 4'h0);
    send(1'b1, AW'(2), 32'h0, 4'h0);
    send(1'b1, AW'(3), 32'h0, 4'h0);
    @(negedge clk);
    chk("t6_pre_rsp_valid", 32'(bus.dtcm_rsp_valid), 32'd1);
    chk("t6_pre_rdata", bus.dtcm_rsp_rdata, 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_rsp_valid", 32'(bus.dtcm_rsp_valid), 32'd0);
    chk("t6_rst_cmd_ready", 32'(bus.dtcm_cmd_ready), 32'd0);
    sync();
    sync();
    rst = 1'b0;
    bus.dtcm_rsp_ready = 1'b1;
    clear_q();
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("t6_no_stale", 32'(rsp_q.size()), 32'd0);
    sync();
    send(1'b1, AW'(7), 32'h0, 4'h0);
    wait_rsp(1, "t6_rsp_count");
    chk("t6_new_rdata", rsp_at(0), 32'd21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
